// File: rtl/router_pkg.sv
// Shared definitions for the input router and its scratchpad fill stage.
package router_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;

   localparam int DEF_DATA_WIDTH      = 8;
   localparam int DEF_SPAD_DATA_WIDTH = 64;

   // Elements per SPAD word; the router and loader must agree on this packing.
   function automatic int spad_n_of(input int data_width, input int spad_data_width);
      return spad_data_width / data_width;
   endfunction

   localparam int DEF_SPAD_N = spad_n_of(DEF_DATA_WIDTH, DEF_SPAD_DATA_WIDTH);

endpackage

// File: rtl/input_spad_loader_word_packer.sv
// Lane register that assembles SPAD_N stream elements into one little-endian SPAD word.
module word_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int SPAD_N     = 8
) (
   input  logic                         clk_i,
   input  logic                         clear_i,
   input  logic                         accept_i,
   input  logic                         flush_i,
   input  logic [DATA_WIDTH-1:0]        data_i,
   output logic                         full_o,
   output logic [DATA_WIDTH*SPAD_N-1:0] word_o
);

   localparam int LANE_W = (SPAD_N > 1) ? $clog2(SPAD_N) : 1;
   localparam int WORD_W = DATA_WIDTH * SPAD_N;

   logic [WORD_W-1:0] lanes_q, lanes_d;
   logic [LANE_W-1:0] lane_q, lane_d;

   assign full_o = (lane_q == LANE_W'(SPAD_N - 1));

   // word_o already contains the byte being accepted, so a flush captures it in the same cycle.
   always_comb begin
      word_o = lanes_q;
      if (accept_i) begin
         word_o[int'(lane_q) * DATA_WIDTH +: DATA_WIDTH] = data_i;
      end
   end

   always_comb begin
      lanes_d = lanes_q;
      lane_d  = lane_q;
      if (accept_i) begin
         if (flush_i) begin
            lanes_d = '0;
            lane_d  = '0;
         end else begin
            lanes_d = word_o;
            lane_d  = lane_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         lanes_q <= '0;
         lane_q  <= '0;
      end else begin
         lanes_q <= lanes_d;
         lane_q  <= lane_d;
      end
   end

endmodule

// File: rtl/input_spad_loader.sv
// Fill stage for the input router scratchpad: packs a byte stream into SPAD words and writes them.
module input_spad_loader
   import router_pkg::*;
#(
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
   parameter int SPAD_DATA_WIDTH = DEF_SPAD_DATA_WIDTH,
   parameter int SPAD_N          = spad_n_of(DATA_WIDTH, SPAD_DATA_WIDTH),
   parameter int ADDR_WIDTH      = 8,
   parameter int CNT_WIDTH       = ADDR_WIDTH + $clog2(SPAD_N)
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_reg_clear,
   input  logic                       i_start,
   input  logic [ADDR_WIDTH-1:0]      i_base_addr,
   input  logic [CNT_WIDTH-1:0]       i_byte_count,
   input  logic [DATA_WIDTH-1:0]      i_data,
   input  logic                       i_valid,
   output logic                       o_ready,
   output logic                       o_spad_write_en,
   output logic [ADDR_WIDTH-1:0]      o_spad_write_addr,
   output logic [SPAD_DATA_WIDTH-1:0] o_spad_data,
   output logic                       o_busy,
   output logic                       o_done
);

   loader_state_t state_q, state_d;

   logic                       clear;
   logic                       start_ok;
   logic                       accept;
   logic                       last_byte;
   logic                       lane_full;
   logic                       trigger;
   logic [SPAD_DATA_WIDTH-1:0] packed_word;

   logic [ADDR_WIDTH-1:0]      base_q;
   logic [CNT_WIDTH-1:0]       count_q;
   logic [CNT_WIDTH-1:0]       byte_idx_q;
   logic [ADDR_WIDTH-1:0]      word_idx_q;

   logic                       we_q;
   logic [ADDR_WIDTH-1:0]      addr_q;
   logic [SPAD_DATA_WIDTH-1:0] data_q;
   logic                       done_q;

   assign clear     = i_rst | i_reg_clear;
   assign start_ok  = (state_q == IDLE) && i_start;
   assign o_ready   = (state_q == LOAD);
   assign o_busy    = (state_q != IDLE);
   assign accept    = o_ready && i_valid;
   assign last_byte = (byte_idx_q == count_q - CNT_WIDTH'(1));
   assign trigger   = accept && (lane_full || last_byte);

   word_packer #(
      .DATA_WIDTH (DATA_WIDTH),
      .SPAD_N     (SPAD_N)
   ) u_packer (
      .clk_i    (i_clk),
      .clear_i  (clear),
      .accept_i (accept),
      .flush_i  (trigger),
      .data_i   (i_data),
      .full_o   (lane_full),
      .word_o   (packed_word)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (i_start) state_d = (i_byte_count != '0) ? LOAD : DONE;
         LOAD: if (accept && last_byte) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Tile parameters are latched only on an accepted start, so a start while busy cannot disturb them.
   always_ff @(posedge i_clk) begin
      if (clear) begin
         base_q     <= '0;
         count_q    <= '0;
         byte_idx_q <= '0;
         word_idx_q <= '0;
      end else if (start_ok) begin
         base_q     <= i_base_addr;
         count_q    <= i_byte_count;
         byte_idx_q <= '0;
         word_idx_q <= '0;
      end else begin
         if (accept)  byte_idx_q <= byte_idx_q + 1'b1;
         if (trigger) word_idx_q <= word_idx_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (clear) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         done_q <= 1'b0;
      end else begin
         we_q   <= trigger;
         done_q <= (state_q == DONE);
         if (trigger) begin
            addr_q <= base_q + word_idx_q;
            data_q <= packed_word;
         end
      end
   end

   assign o_spad_write_en   = we_q;
   assign o_spad_write_addr = addr_q;
   assign o_spad_data       = data_q;
   assign o_done            = done_q;

endmodule

// File: tb/tb_input_spad_loader.sv
// Scoreboard bench for input_spad_loader: expected SPAD writes are queued as stimulus is driven.
module tb_input_spad_loader;

   typedef struct {
      logic [7:0]  addr;
      logic [63:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_reg_clear = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_base_addr = '0;
   logic [10:0] i_byte_count = '0;
   logic [7:0]  i_data = '0;
   logic        i_valid = 1'b0;
   logic        o_ready, o_spad_write_en, o_busy, o_done;
   logic [7:0]  o_spad_write_addr;
   logic [63:0] o_spad_data;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   writes = 0;
   wr_t  exp_q[$];
   logic [7:0] tile [0:31];

   input_spad_loader dut (
      .i_clk             (clk),
      .i_rst             (i_rst),
      .i_reg_clear       (i_reg_clear),
      .i_start           (i_start),
      .i_base_addr       (i_base_addr),
      .i_byte_count      (i_byte_count),
      .i_data            (i_data),
      .i_valid           (i_valid),
      .o_ready           (o_ready),
      .o_spad_write_en   (o_spad_write_en),
      .o_spad_write_addr (o_spad_write_addr),
      .o_spad_data       (o_spad_data),
      .o_busy            (o_busy),
      .o_done            (o_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every observed write is matched against the head of the expectation queue.
   always @(negedge clk) begin
      if (o_spad_write_en) begin
         wr_t e;
         writes++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: addr=%02h data=%016h, required no write", o_spad_write_addr, o_spad_data);
         end else begin
            e = exp_q.pop_front();
            if (o_spad_write_addr !== e.addr || o_spad_data !== e.data) begin
               bad++;
               $display("FAIL write: got addr=%02h data=%016h, required addr=%02h data=%016h",
                        o_spad_write_addr, o_spad_data, e.addr, e.data);
            end
         end
      end
   end

   function automatic void push_tile(input logic [7:0] base, input int n);
      wr_t w;
      for (int wi = 0; wi * 8 < n; wi++) begin
         w.addr = base + 8'(wi);
         w.data = '0;
         for (int l = 0; l < 8; l++)
            if (wi * 8 + l < n) w.data[l*8 +: 8] = tile[wi*8 + l];
         exp_q.push_back(w);
      end
   endfunction

   function automatic void push_word(input logic [7:0] a, input logic [63:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endfunction

   // Caller is positioned #1 after a rising edge; returns aligned the same way.
   task automatic drive_load(input logic [7:0] base, input int n, input bit toggle, input int start_at,
                             output int t_last, output int acc, output int ready_lows);
      int guard;
      t_last = 0; acc = 0; ready_lows = 0; guard = 0;
      i_start = 1'b1; i_base_addr = base; i_byte_count = 11'(n);
      @(posedge clk); #1;
      i_start = 1'b0;
      i_valid = 1'b0;
      while (acc < n && guard < 100) begin
         i_valid = toggle ? ~i_valid : 1'b1;
         i_data  = tile[acc];
         if (acc == start_at && i_valid) begin
            i_start = 1'b1; i_base_addr = 8'h50; i_byte_count = 11'd3;
         end else begin
            i_start = 1'b0;
         end
         if (!o_ready) ready_lows++;
         if (i_valid && o_ready) begin
            t_last = cyc;
            acc++;
         end
         @(posedge clk); #1;
         guard++;
      end
      i_valid = 1'b0;
      i_start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (o_ready !== 1'b0)         begin bad++; $display("FAIL reset_ready: got %b required 0", o_ready); end
      total++; if (o_spad_write_en !== 1'b0) begin bad++; $display("FAIL reset_we: got %b required 0", o_spad_write_en); end
      total++; if (o_spad_write_addr !== 8'h00) begin bad++; $display("FAIL reset_addr: got %02h required 00", o_spad_write_addr); end
      total++; if (o_spad_data !== 64'h0)    begin bad++; $display("FAIL reset_data: got %016h required 0", o_spad_data); end
      total++; if (o_busy !== 1'b0)          begin bad++; $display("FAIL reset_busy: got %b required 0", o_busy); end
      total++; if (o_done !== 1'b0)          begin bad++; $display("FAIL reset_done: got %b required 0", o_done); end
      i_rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_load(input string name, input logic [7:0] base, input int n, input bit toggle,
                            input int start_at, input int exp_writes, input bit use_model);
      int t_last, acc, ready_lows, w0, dcyc;
      w0 = writes;
      for (int i = 0; i < 32; i++) tile[i] = 8'(i + 1);
      if (use_model) push_tile(base, n);
      drive_load(base, n, toggle, start_at, t_last, acc, ready_lows);
      total++; if (acc !== n) begin bad++; $display("FAIL %s_accepted: got %0d required %0d", name, acc, n); end
      total++; if (ready_lows !== 0) begin bad++; $display("FAIL %s_ready_low: got %0d required 0", name, ready_lows); end
      dcyc = -1;
      for (int w = 0; w < 10; w++) begin
         @(negedge clk);
         if (o_done) begin dcyc = cyc; break; end
      end
      total++; if (dcyc !== t_last + 2) begin bad++; $display("FAIL %s_done_cycle: got %0d required %0d", name, dcyc, t_last + 2); end
      @(posedge clk); #1;
      total++; if (writes - w0 !== exp_writes) begin bad++; $display("FAIL %s_write_count: got %0d required %0d", name, writes - w0, exp_writes); end
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL %s_pending: got %0d required 0", name, exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_full_tile();
      push_word(8'h10, 64'h0807060504030201);
      push_word(8'h11, 64'h100F0E0D0C0B0A09);
      test_load("full", 8'h10, 16, 1'b0, -1, 2, 1'b0);
   endtask

   task automatic test_partial();
      push_word(8'h00, 64'h0807060504030201);
      push_word(8'h01, 64'h00000000000B0A09);
      test_load("partial", 8'h00, 11, 1'b0, -1, 2, 1'b0);
   endtask

   task automatic test_toggle_valid();
      test_load("toggle", 8'h40, 8, 1'b1, -1, 1, 1'b1);
   endtask

   task automatic test_wrap();
      push_word(8'hFF, 64'h0807060504030201);
      push_word(8'h00, 64'h100F0E0D0C0B0A09);
      test_load("wrap", 8'hFF, 16, 1'b0, -1, 2, 1'b0);
   endtask

   task automatic test_start_mid_load();
      test_load("midstart", 8'h30, 8, 1'b0, 4, 1, 1'b1);
   endtask

   task automatic test_abort(input bit use_clear);
      int w0;
      w0 = writes;
      for (int i = 0; i < 8; i++) tile[i] = 8'hC0 + 8'(i);
      i_start = 1'b1; i_base_addr = 8'h20; i_byte_count = 11'd8;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         i_valid = 1'b1; i_data = tile[i];
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      if (use_clear) i_reg_clear = 1'b1; else i_rst = 1'b1;
      @(posedge clk); #1;
      i_reg_clear = 1'b0; i_rst = 1'b0;
      total++; if ({o_ready, o_spad_write_en, o_busy, o_done} !== 4'b0000)
         begin bad++; $display("FAIL abort%0d_ctrl: got %b required 0000", use_clear, {o_ready, o_spad_write_en, o_busy, o_done}); end
      total++; if (o_spad_write_addr !== 8'h00 || o_spad_data !== 64'h0)
         begin bad++; $display("FAIL abort%0d_dataout: got %02h/%016h required 00/0", use_clear, o_spad_write_addr, o_spad_data); end
      repeat (3) @(posedge clk); #1;
      total++; if (writes - w0 !== 0) begin bad++; $display("FAIL abort%0d_nowrite: got %0d required 0", use_clear, writes - w0); end
      push_word(8'h21, 64'hA7A6A5A4A3A2A1A0);
      for (int i = 0; i < 8; i++) tile[i] = 8'hA0 + 8'(i);
      begin
         int t_last, acc, rl;
         drive_load(8'h21, 8, 1'b0, -1, t_last, acc, rl);
      end
      repeat (3) @(posedge clk); #1;
      total++; if (writes - w0 !== 1) begin bad++; $display("FAIL abort%0d_reload_writes: got %0d required 1", use_clear, writes - w0); end
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL abort%0d_pending: got %0d required 0", use_clear, exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_zero_count();
      int s, w0, dcyc;
      w0 = writes;
      s = cyc;
      i_start = 1'b1; i_base_addr = 8'h77; i_byte_count = 11'd0;
      @(posedge clk); #1;
      i_start = 1'b0;
      total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL zero_busy: got %b required 1", o_busy); end
      dcyc = -1;
      for (int w = 0; w < 10; w++) begin
         @(negedge clk);
         if (o_done) begin dcyc = cyc; break; end
      end
      total++; if (dcyc !== s + 2) begin bad++; $display("FAIL zero_done_cycle: got %0d required %0d", dcyc, s + 2); end
      @(posedge clk); #1;
      total++; if (writes - w0 !== 0) begin bad++; $display("FAIL zero_nowrite: got %0d required 0", writes - w0); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL zero_idle: got %b required 0", o_busy); end
   endtask

   initial begin
      test_reset();
      test_full_tile();
      test_partial();
      test_toggle_valid();
      test_wrap();
      test_abort(1'b0);
      test_abort(1'b1);
      test_zero_count();
      test_start_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
